controller: RTL

CONTROLLER -- requirements
Module: controller

---
 rtl/controller.sv | 55 +++++
 1 files changed

// File: rtl/controller.sv
// controller: 8-phase instruction sequencer for a simple accumulator CPU
// Ports: clk, rst (async active-high); opcode/zero in; phase plus the
// datapath strobes sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr out.
module controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic [2:0] phase,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       halt,
  output logic       data_e,
  output logic       ld_ac,
  output logic       wr
);
  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND = 3'd3,
                         XOR = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;
  typedef enum logic [2:0] {
    INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE
  } phase_t;
  phase_t state;
  logic   halted;
  logic   hlt_now;
  logic   alu_op;
  logic   run;
  assign hlt_now = state == OP_ADDR && opcode == HLT;
  assign alu_op  = opcode inside {ADD, AND, XOR, LDA};
  assign run     = !halted;
  // The halting edge also freezes phase, so the machine parks at OP_ADDR.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= INST_ADDR;
      halted <= 1'b0;
    end else begin
      if (hlt_now) halted <= 1'b1;
      if (run && !hlt_now) state <= phase_t'(state + 3'd1);
    end
  assign phase  = state;
  assign sel    = run && state inside {INST_ADDR, INST_FETCH, INST_LOAD, IDLE};
  assign rd     = run && (state inside {INST_FETCH, INST_LOAD, IDLE} ||
                          (state inside {OP_FETCH, ALU_OP, STORE} && alu_op));
  assign ld_ir  = run && state inside {INST_LOAD, IDLE};
  assign inc_pc = run && (state == OP_ADDR ||
                          (state == ALU_OP && opcode == SKZ && zero) ||
                          (state == STORE && opcode == JMP));
  assign ld_pc  = run && state inside {ALU_OP, STORE} && opcode == JMP;
  assign halt   = halted || hlt_now;
  assign data_e = run && state inside {ALU_OP, STORE} && opcode == STO;
  assign ld_ac  = run && state == STORE && alu_op;
  assign wr     = run && state == STORE && opcode == STO;
endmodule
